// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational hits, block refill one word per
// memory handshake, per-set LRU (2-way), whole-cache invalidate, saturating hit/miss counters.
module icache_sa #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        inval,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OB  = $clog2(BLKWORDS);
  localparam int IB  = $clog2(SETS);
  localparam int TB  = 30 - OB - IB;
  localparam int OBW = (OB > 0) ? OB : 1;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_n;

  logic [SETS-1:0] valid [WAYS];
  logic [TB-1:0]   tags  [WAYS][SETS];
  logic [31:0]     data  [WAYS][SETS][BLKWORDS];
  logic [SETS-1:0] lru;  // per set: way to evict next

  logic [IB-1:0]  idx;
  logic [TB-1:0]  tag;
  logic [OBW-1:0] woff;
  logic           hit_any, hit_way, victim, miss, accept, last;
  logic [IB-1:0]  r_idx;
  logic [TB-1:0]  r_tag;
  logic           r_way;
  logic [OBW-1:0] cnt;
  logic           unused_bits;

  assign unused_bits = ^imemaddr[1:0];
  assign idx  = imemaddr[2+OB +: IB];
  assign tag  = imemaddr[31 -: TB];
  assign woff = (OB > 0) ? imemaddr[2 +: OBW] : '0;

  always_comb begin
    hit_any = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][idx] && tags[w][idx] == tag) begin
        hit_any = 1'b1;
        hit_way = w[0];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to LRU.
  always_comb begin
    victim = (WAYS == 2) ? lru[idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][idx]) victim = w[0];
    end
  end

  assign ihit     = (state == IDLE) && imemREN && !RST && !inval && hit_any;
  assign miss     = (state == IDLE) && imemREN && !RST && !inval && !hit_any;
  assign imemload = ihit ? data[hit_way][idx][woff] : '0;
  assign accept   = (state == REFILL) && !iwait && !inval && !RST;
  assign last     = (cnt == OBW'(BLKWORDS - 1));
  assign iREN     = (state == REFILL) && !RST;
  assign iaddr    = iREN ? ({r_tag, r_idx, {(OB+2){1'b0}}} | (32'(cnt) << 2)) : '0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (miss) state_n = REFILL;
      REFILL:  if (inval || (accept && last)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      lru        <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_way      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end else begin
      state <= state_n;
      if (inval) begin
        for (int w = 0; w < WAYS; w++) valid[w] <= '0;
        lru <= '0;
      end else if (ihit) begin
        if (WAYS == 2) lru[idx] <= ~hit_way;
      end else if (accept && last) begin
        valid[r_way][r_idx] <= 1'b1;
        if (WAYS == 2) lru[r_idx] <= ~r_way;
      end
      if (ihit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (miss) begin
        r_idx <= idx;
        r_tag <= tag;
        r_way <= victim;
        cnt   <= '0;
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
      if (accept) cnt <= cnt + OBW'(1);
    end
  end

  // Storage arrays carry no reset; validity is tracked separately.
  always_ff @(posedge CLK) begin
    if (accept) data[r_way][r_idx][cnt] <= iload;
    if (accept && last) tags[r_way][r_idx] <= r_tag;
  end
endmodule
